operand_fetch: RTL and testbench

Operand-fetch and issue stage directly upstream of the 16-bit ALU: holds the 8-entry general register file, resolves read-after-write hazards with a per-register pending scoreboard, and presents a registered `code`/`src`/`dst` operand bundle to the ALU through a valid/ready handshake. The write-back path (ALU result and flag byte) returns here and updates the register file and flag register.

---
 rtl/operand_fetch.sv | 88 ++++++++
 tb/tb_operand_fetch.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// operand_fetch: register file, RAW pending scoreboard and registered operand issue to the ALU
module operand_fetch #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_code,
    input  logic [AW-1:0]    in_src_sel,
    input  logic [AW-1:0]    in_dst_sel,
    input  logic             in_imm_en,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             in_wr_en,
    input  logic [AW-1:0]    in_wr_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_code,
    output logic [WIDTH-1:0] out_src,
    output logic [WIDTH-1:0] out_dst,
    output logic             out_wr_en,
    output logic [AW-1:0]    out_wr_sel,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_sel,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             flg_we,
    input  logic [7:0]       flg_in,
    output logic [7:0]       flags
);
    localparam int N = 2**AW;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] regs [N];
    logic [N-1:0]     pending, clr, set;
    logic             src_byp, dst_byp, wr_byp, hazard, accept;
    logic [WIDTH-1:0] src_val, dst_val;

    always_comb begin
        src_byp = wb_en && wb_sel == in_src_sel;
        dst_byp = wb_en && wb_sel == in_dst_sel;
        wr_byp  = wb_en && wb_sel == in_wr_sel;
        src_val = (in_src_sel == '0) ? '0 : src_byp ? wb_data : regs[in_src_sel];
        dst_val = in_imm_en ? in_imm : (in_dst_sel == '0) ? '0 : dst_byp ? wb_data : regs[in_dst_sel];
        hazard  = (pending[in_src_sel] && !src_byp) ||
                  (!in_imm_en && pending[in_dst_sel] && !dst_byp) ||
                  (in_wr_en && pending[in_wr_sel] && !wr_byp);
        in_ready = (!out_valid || out_ready) && !hazard;
        accept   = in_valid && in_ready;
        clr = wb_en ? ONE << wb_sel : '0;
        // a new producer claiming the register outranks a retiring one in the same cycle
        set = (accept && in_wr_en && in_wr_sel != '0) ? ONE << in_wr_sel : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
        end else if (wb_en && wb_sel != '0) begin
            regs[wb_sel] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            flags      <= '0;
            out_valid  <= 1'b0;
            out_code   <= '0;
            out_src    <= '0;
            out_dst    <= '0;
            out_wr_en  <= 1'b0;
            out_wr_sel <= '0;
        end else begin
            pending <= (pending & ~clr) | set;
            if (flg_we) flags <= flg_in;
            if (accept) begin
                out_valid  <= 1'b1;
                out_code   <= in_code;
                out_src    <= src_val;
                out_dst    <= dst_val;
                out_wr_en  <= in_wr_en;
                out_wr_sel <= in_wr_sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: scoreboard bench for the operand fetch / issue stage
module tb_operand_fetch;
    localparam int WIDTH = 16;
    localparam int AW    = 3;

    typedef struct packed {
        logic [3:0]       code;
        logic [WIDTH-1:0] src;
        logic [WIDTH-1:0] dst;
        logic             wr_en;
        logic [AW-1:0]    wr_sel;
    } bundle_t;

    logic             clk = 0, rst = 1;
    logic             in_valid = 0, in_ready, in_imm_en = 0, in_wr_en = 0;
    logic [3:0]       in_code = 0, out_code;
    logic [AW-1:0]    in_src_sel = 0, in_dst_sel = 0, in_wr_sel = 0, out_wr_sel, wb_sel = 0;
    logic [WIDTH-1:0] in_imm = 0, out_src, out_dst, wb_data = 0;
    logic             out_valid, out_ready = 1, out_wr_en, wb_en = 0, flg_we = 0;
    logic [7:0]       flg_in = 0, flags;

    int checks = 0, errors = 0;
    bundle_t q[$];
    bundle_t exp_b, got_b;
    logic [WIDTH-1:0] m_regs [2**AW];

    operand_fetch #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .in_src_sel(in_src_sel), .in_dst_sel(in_dst_sel), .in_imm_en(in_imm_en), .in_imm(in_imm),
        .in_wr_en(in_wr_en), .in_wr_sel(in_wr_sel), .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_src(out_src), .out_dst(out_dst), .out_wr_en(out_wr_en),
        .out_wr_sel(out_wr_sel), .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
        .flg_we(flg_we), .flg_in(flg_in), .flags(flags)
    );

    always #5 clk = ~clk;

    // transfers to the ALU are compared against the queue in order
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            got_b = {out_code, out_src, out_dst, out_wr_en, out_wr_sel};
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_bundle got=%h", got_b);
            end else begin
                exp_b = q.pop_front();
                if (got_b !== exp_b) begin
                    errors++;
                    $display("FAIL bundle got=%h exp=%h", got_b, exp_b);
                end
            end
        end
    end

    function automatic logic [WIDTH-1:0] rd(input logic [AW-1:0] sel);
        return (sel == 0) ? '0 : (wb_en && wb_sel == sel) ? wb_data : m_regs[sel];
    endfunction

    task automatic idle();
        in_valid = 0; in_imm_en = 0; in_wr_en = 0; wb_en = 0; flg_we = 0; out_ready = 1;
    endtask

    task automatic issue(input logic [3:0] code, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic imm_en, input logic [WIDTH-1:0] imm,
                         input logic wr_en, input logic [AW-1:0] wr_sel);
        in_valid = 1; in_code = code; in_src_sel = src; in_dst_sel = dst;
        in_imm_en = imm_en; in_imm = imm; in_wr_en = wr_en; in_wr_sel = wr_sel;
    endtask

    task automatic wb(input logic [AW-1:0] sel, input logic [WIDTH-1:0] data);
        wb_en = 1; wb_sel = sel; wb_data = data;
    endtask

    task automatic step(input logic exp_rdy, input string name);
        @(negedge clk);
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL %s in_ready=%b exp=%b", name, in_ready, exp_rdy);
        end
        if (in_valid && exp_rdy)
            q.push_back({in_code, rd(in_src_sel), in_imm_en ? in_imm : rd(in_dst_sel), in_wr_en, in_wr_sel});
        @(posedge clk);
        if (wb_en && wb_sel != 0) m_regs[wb_sel] = wb_data;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_fields", 32'({out_code, out_src, out_wr_en, out_wr_sel} | 32'(out_dst)), 0);
        chk("rst_flags", 32'(flags), 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #1 chk("rst_in_ready", 32'(in_ready), 1);
    endtask

    task automatic test_basic();
        idle(); wb(3, 16'h1234);
        step(1, "basic_wb");
        idle(); issue(0, 3, 0, 1, 16'h0001, 0, 0);
        step(1, "basic_issue");
        chk("basic_out_src", 32'(out_src), 32'h1234);
        chk("basic_out_dst", 32'(out_dst), 32'h0001);
        idle(); issue(4'h9, 3, 3, 0, 0, 1, 4);
        step(1, "basic_reg_dst");
        idle(); wb(4, 16'h4444);
        step(1, "basic_wb4");
    endtask

    task automatic test_hazard();
        idle(); issue(4'h2, 1, 0, 1, 16'h00AA, 1, 5);
        step(1, "haz_producer");
        idle(); issue(4'h3, 5, 0, 1, 16'h0002, 0, 0);
        step(0, "haz_stall");
        wb(5, 16'hBEEF);
        step(1, "haz_bypass");
        chk("haz_out_src", 32'(out_src), 32'hBEEF);
        idle(); issue(4'h4, 2, 5, 0, 0, 0, 0);
        step(1, "haz_dst_from_store");
    endtask

    task automatic test_stall();
        idle(); issue(4'h7, 3, 0, 1, 16'h0055, 0, 0);
        step(1, "stall_first");
        issue(4'h8, 3, 0, 1, 16'h0066, 0, 0);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, "stall_blocked");
            chk("stall_hold", {out_valid, 3'b0, out_code, out_src, out_dst[7:0]}, {4'h8, 4'h7, 16'h1234, 8'h55});
        end
        out_ready = 1;
        step(1, "stall_release");
        issue(4'hA, 4, 3, 0, 0, 0, 0);
        step(1, "b2b_1");
        issue(4'hB, 5, 0, 1, 16'hCAFE, 0, 0);
        step(1, "b2b_2");
        idle();
        step(1, "b2b_drain");
    endtask

    task automatic test_r0();
        idle(); wb(0, 16'hFFFF);
        step(1, "r0_write");
        idle(); issue(4'h1, 0, 0, 1, 16'h0003, 1, 0);
        step(1, "r0_issue");
        chk("r0_out_src", 32'(out_src), 0);
        idle(); issue(4'h1, 0, 0, 0, 0, 0, 0);
        step(1, "r0_no_stall");
        chk("r0_out_dst", 32'(out_dst), 0);
    endtask

    task automatic test_set_wins();
        idle(); issue(4'h5, 1, 0, 1, 16'h0010, 1, 2);
        step(1, "sw_first");
        issue(4'h6, 1, 0, 1, 16'h0020, 1, 2);
        wb(2, 16'h2222);
        step(1, "sw_same_cycle");
        idle(); issue(4'hC, 2, 0, 1, 16'h0030, 0, 0);
        step(0, "sw_still_pending");
        wb(2, 16'h3333);
        step(1, "sw_release");
        idle();
        step(1, "sw_drain");
    endtask

    task automatic test_flags_reset();
        idle(); flg_we = 1; flg_in = 8'hA0;
        step(1, "flg_we");
        chk("flags_load", 32'(flags), 32'hA0);
        idle(); issue(4'hD, 3, 4, 0, 0, 1, 6);
        step(1, "mid_issue");
        idle();
        rst = 1;
        #1;
        chk("mid_rst_flags", 32'(flags), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        q.delete();
        for (int i = 0; i < 2**AW; i++) m_regs[i] = '0;
        @(posedge clk);
        #1 rst = 0;
        issue(4'hE, 6, 6, 0, 0, 0, 0);
        step(1, "post_rst_no_pending");
        chk("post_rst_regs", 32'({out_src, out_dst}), 0);
        idle();
        step(1, "final_drain");
        chk("queue_empty", 32'(q.size()), 0);
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) m_regs[i] = '0;
        test_reset();
        test_basic();
        test_hazard();
        test_stall();
        test_r0();
        test_set_wins();
        test_flags_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
